// File: rtl/sound_pkg.sv
// Shared types, constants and helpers for the sound arbiter and its tone
// generator: FSM state encoding, default SFX periods, amplitude base and
// millisecond-to-cycle conversion.
package sound_pkg;

   // Arbiter states; the encoding is fixed so other blocks can decode it.
   typedef enum logic [1:0] {
      ST_BGM = 2'd0,
      ST_SFX = 2'd1,
      ST_GAP = 2'd2
   } state_e;

   // Width of a tone period in clk cycles (covers the longest SFX period).
   localparam int DIV_W   = 22;
   // Width of the ms timers; wide enough for long bursts at 100 MHz.
   localparam int TIMER_W = 32;
   // Width of an audio sample.
   localparam int SAMPLE_W = 16;

   // Amplitude at volume 0 before the shift; volume n gives base << n.
   localparam logic [SAMPLE_W-1:0] AMP_BASE = 16'h0080;

   // Default SFX periods in clk cycles at 100 MHz, indexed by cur_sfx.
   localparam int unsigned SFX0_DIV_DEF = 190840;  // key found, ~524 Hz
   localparam int unsigned SFX1_DIV_DEF = 381680;  // damage, ~262 Hz
   localparam int unsigned SFX2_DIV_DEF = 95420;   // stage clear, ~1048 Hz

   // Convert a duration in ms to a number of clk cycles.
   function automatic logic [TIMER_W-1:0] ms_to_cycles(input int unsigned ms,
                                                       input int unsigned clk_hz);
      logic [63:0] prod;
      prod = (64'(ms) * 64'(clk_hz)) / 64'd1000;
      return prod[TIMER_W-1:0];
   endfunction

   // Select the period of the SFX with index idx.
   function automatic logic [DIV_W-1:0] sfx_div(input logic [1:0]       idx,
                                                input logic [DIV_W-1:0] d0,
                                                input logic [DIV_W-1:0] d1,
                                                input logic [DIV_W-1:0] d2);
      logic [DIV_W-1:0] d;
      case (idx)
         2'd0:    d = d0;
         2'd1:    d = d1;
         default: d = d2;
      endcase
      return d;
   endfunction

   // Output amplitude for a volume level; muted or level 0 means silence.
   function automatic logic [SAMPLE_W-1:0] amp_for(input logic [2:0] vol,
                                                   input logic       mute);
      logic [SAMPLE_W-1:0] a;
      if (mute || (vol == 3'd0)) begin
         a = '0;
      end else begin
         a = AMP_BASE << vol;
      end
      return a;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator. A period counter runs 0..div-1 and restarts
// whenever the requested period changes; the signed sample register follows
// the counter by one cycle (+amp in the first half period, -amp in the rest).
module tone_gen
   import sound_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [DIV_W-1:0]    div_i,
   input  logic [SAMPLE_W-1:0] amp_i,
   output logic [SAMPLE_W-1:0] sample_o
);

   logic [DIV_W-1:0]    div_q;
   logic [DIV_W-1:0]    cnt_q;
   logic [DIV_W-1:0]    cnt_d;
   logic [SAMPLE_W-1:0] sample_q;
   logic [SAMPLE_W-1:0] sample_d;
   logic                silent;

   // A period below 2 cycles cannot form a square wave, so it means rest.
   assign silent = (div_q < DIV_W'(2));

   // Next count: restart on a period change, hold at 0 when silent, else wrap.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      cnt_d = '0;
      if ((div_i == div_q) && !silent && (cnt_q != (div_q - DIV_W'(1)))) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   // Sample from the current count: high half, low half, or silence.
   always_comb begin
      sample_d = '0;
      if (!silent && (amp_i != '0)) begin
         if (cnt_q < (div_q >> 1)) begin
            sample_d = amp_i;
         end else begin
            sample_d = (~amp_i) + SAMPLE_W'(1);
         end
      end
   end

   // Period, counter and sample registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         div_q    <= '0;
         cnt_q    <= '0;
         sample_q <= '0;
      end else begin
         div_q    <= div_i;
         cnt_q    <= cnt_d;
         sample_q <= sample_d;
      end
   end

   assign sample_o = sample_q;

endmodule

// File: rtl/sound_arbiter.sv
// Sound arbiter: shares the single speaker channel between background music
// and three prioritised sound effects, applies volume and mute, and drives
// identical left/right samples to speaker_control.
module sound_arbiter
   import sound_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned SFX_LEN_MS = 200,
   parameter int unsigned GAP_MS     = 20,
   parameter int unsigned VOL_INIT   = 3,
   parameter int unsigned SFX0_DIV   = SFX0_DIV_DEF,
   parameter int unsigned SFX1_DIV   = SFX1_DIV_DEF,
   parameter int unsigned SFX2_DIV   = SFX2_DIV_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                vol_up_i,
   input  logic                vol_down_i,
   input  logic                mute_i,
   input  logic                bgm_en_i,
   input  logic [DIV_W-1:0]    bgm_div_i,
   input  logic [2:0]          sfx_req_i,
   output logic [SAMPLE_W-1:0] audio_left_o,
   output logic [SAMPLE_W-1:0] audio_right_o,
   output logic [2:0]          volume_o,
   output logic                sfx_active_o,
   output logic [1:0]          cur_sfx_o
);

   // Timer reload values: the timer counts down to 0 inclusive, so a burst of
   // N cycles loads N-1.
   localparam logic [TIMER_W-1:0] SFX_RELOAD = ms_to_cycles(SFX_LEN_MS, CLK_HZ) - TIMER_W'(1);
   localparam logic [TIMER_W-1:0] GAP_RELOAD = ms_to_cycles(GAP_MS, CLK_HZ) - TIMER_W'(1);

   localparam logic [DIV_W-1:0] SFX0_DIV_C = DIV_W'(SFX0_DIV);
   localparam logic [DIV_W-1:0] SFX1_DIV_C = DIV_W'(SFX1_DIV);
   localparam logic [DIV_W-1:0] SFX2_DIV_C = DIV_W'(SFX2_DIV);
   localparam logic [2:0]       VOL_RESET  = 3'(VOL_INIT);

   state_e              state_q;
   state_e              state_d;
   logic [TIMER_W-1:0]  timer_q;
   logic [TIMER_W-1:0]  timer_d;
   logic [1:0]          cur_sfx_q;
   logic [1:0]          cur_sfx_d;
   logic                sfx_active_q;
   logic [2:0]          volume_q;
   logic [2:0]          volume_d;

   logic                req_any;
   logic [1:0]          req_idx;
   logic [DIV_W-1:0]    active_div;
   logic [SAMPLE_W-1:0] amp;
   logic [SAMPLE_W-1:0] sample;

   // Highest requested SFX index; bit 2 wins over bit 1 over bit 0.
   assign req_any = |sfx_req_i;
   assign req_idx = sfx_req_i[2] ? 2'd2 : (sfx_req_i[1] ? 2'd1 : 2'd0);

   // Saturating volume step; simultaneous up and down cancel.
   always_comb begin
      volume_d = volume_q;
      if (vol_up_i && !vol_down_i && (volume_q != 3'd7)) begin
         volume_d = volume_q + 3'd1;
      end else if (vol_down_i && !vol_up_i && (volume_q != 3'd0)) begin
         volume_d = volume_q - 3'd1;
      end
   end

   // Arbitration FSM: BGM until a request, SFX burst with preempt/retrigger,
   // then a short silent gap before music resumes.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      cur_sfx_d = cur_sfx_q;
      case (state_q)
         ST_BGM: begin
            if (req_any) begin
               state_d   = ST_SFX;
               cur_sfx_d = req_idx;
               timer_d   = SFX_RELOAD;
            end
         end
         ST_SFX: begin
            // An equal index retriggers, a higher one preempts, a lower one
            // is dropped and the burst continues.
            if (req_any && (req_idx >= cur_sfx_q)) begin
               cur_sfx_d = req_idx;
               timer_d   = SFX_RELOAD;
            end else if (timer_q == '0) begin
               state_d = ST_GAP;
               timer_d = GAP_RELOAD;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         ST_GAP: begin
            if (req_any) begin
               state_d   = ST_SFX;
               cur_sfx_d = req_idx;
               timer_d   = SFX_RELOAD;
            end else if (timer_q == '0) begin
               state_d = ST_BGM;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: begin
            state_d = ST_BGM;
            timer_d = '0;
         end
      endcase
   end

   // Period of whatever currently owns the channel; 0 means silence.
   always_comb begin
      active_div = '0;
      case (state_q)
         ST_BGM:  active_div = bgm_en_i ? bgm_div_i : '0;
         ST_SFX:  active_div = sfx_div(cur_sfx_q, SFX0_DIV_C, SFX1_DIV_C, SFX2_DIV_C);
         default: active_div = '0;
      endcase
   end

   // Arbiter state, timer, SFX index, activity flag and volume registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_BGM;
         timer_q      <= '0;
         cur_sfx_q    <= 2'd0;
         sfx_active_q <= 1'b0;
         volume_q     <= VOL_RESET;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         cur_sfx_q    <= cur_sfx_d;
         sfx_active_q <= (state_d == ST_SFX);
         volume_q     <= volume_d;
      end
   end

   // Mute silences the output without touching the stored volume.
   assign amp = amp_for(volume_q, mute_i);

   tone_gen u_tone_gen (
      .clk      (clk),
      .rst      (rst),
      .div_i    (active_div),
      .amp_i    (amp),
      .sample_o (sample)
   );

   assign audio_left_o  = sample;
   assign audio_right_o = sample;
   assign volume_o      = volume_q;
   assign sfx_active_o  = sfx_active_q;
   assign cur_sfx_o     = cur_sfx_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Self-checking bench for sound_arbiter. Timers are shortened through the
// parameters: 1 ms = 100 cycles, so an SFX burst is 200 cycles and the gap
// is 100 cycles; SFX periods are 40/60/20 cycles.
module tb_sound_arbiter;
   import sound_pkg::*;

   localparam int unsigned CLK_HZ     = 100_000;
   localparam int unsigned SFX_LEN_MS = 2;
   localparam int unsigned GAP_MS     = 1;
   localparam int unsigned VOL_INIT   = 3;
   localparam int unsigned SFX0_DIV   = 40;
   localparam int unsigned SFX1_DIV   = 60;
   localparam int unsigned SFX2_DIV   = 20;

   localparam int SFX_CYC = 200;
   localparam int GAP_CYC = 100;

   logic             clk = 1'b0;
   logic             rst;
   logic             vol_up;
   logic             vol_down;
   logic             mute;
   logic             bgm_en;
   logic [21:0]      bgm_div;
   logic [2:0]       sfx_req;
   logic [15:0]      audio_left;
   logic [15:0]      audio_right;
   logic [2:0]       volume;
   logic             sfx_active;
   logic [1:0]       cur_sfx;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   sound_arbiter #(
      .CLK_HZ     (CLK_HZ),
      .SFX_LEN_MS (SFX_LEN_MS),
      .GAP_MS     (GAP_MS),
      .VOL_INIT   (VOL_INIT),
      .SFX0_DIV   (SFX0_DIV),
      .SFX1_DIV   (SFX1_DIV),
      .SFX2_DIV   (SFX2_DIV)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .vol_up_i      (vol_up),
      .vol_down_i    (vol_down),
      .mute_i        (mute),
      .bgm_en_i      (bgm_en),
      .bgm_div_i     (bgm_div),
      .sfx_req_i     (sfx_req),
      .audio_left_o  (audio_left),
      .audio_right_o (audio_right),
      .volume_o      (volume),
      .sfx_active_o  (sfx_active),
      .cur_sfx_o     (cur_sfx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       up;
      logic       down;
      logic [2:0] exp_vol;
   } vol_vec_t;

   vol_vec_t vv[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic pulse_req(input logic [2:0] r);
      sfx_req = r;
      tick();
      sfx_req = 3'b000;
   endtask

   // Count consecutive samples equal to val, bounded by limit.
   task automatic run_len(input logic [15:0] val, input int limit, output int n);
      n = 0;
      while ((audio_left == val) && (n < limit)) begin
         n++;
         tick();
      end
   endtask

   // Wait for sfx_active to drop, bounded by limit cycles.
   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (sfx_active && (n < limit)) begin
         n++;
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int t0;

      vv[0]  = '{1'b1, 1'b0, 3'd4};
      vv[1]  = '{1'b1, 1'b0, 3'd5};
      vv[2]  = '{1'b1, 1'b0, 3'd6};
      vv[3]  = '{1'b1, 1'b0, 3'd7};
      vv[4]  = '{1'b1, 1'b0, 3'd7};
      vv[5]  = '{1'b0, 1'b1, 3'd6};
      vv[6]  = '{1'b0, 1'b1, 3'd5};
      vv[7]  = '{1'b0, 1'b1, 3'd4};
      vv[8]  = '{1'b0, 1'b1, 3'd3};
      vv[9]  = '{1'b0, 1'b1, 3'd2};
      vv[10] = '{1'b0, 1'b1, 3'd1};
      vv[11] = '{1'b0, 1'b1, 3'd0};
      vv[12] = '{1'b0, 1'b1, 3'd0};
      vv[13] = '{1'b1, 1'b1, 3'd0};
      vv[14] = '{1'b1, 1'b0, 3'd1};
      vv[15] = '{1'b1, 1'b1, 3'd1};

      rst      = 1'b1;
      vol_up   = 1'b0;
      vol_down = 1'b0;
      mute     = 1'b0;
      bgm_en   = 1'b0;
      bgm_div  = '0;
      sfx_req  = 3'b000;

      tick();
      tick();
      check("rst_audio_l", 32'(audio_left), 32'h0);
      check("rst_audio_r", 32'(audio_right), 32'h0);
      check("rst_volume", 32'(volume), 32'(VOL_INIT));
      check("rst_sfx_active", 32'(sfx_active), 32'h0);
      check("rst_cur_sfx", 32'(cur_sfx), 32'h0);
      rst = 1'b0;
      tick();

      // Volume stepping, saturation and cancel.
      for (int i = 0; i < 16; i++) begin
         vol_up   = vv[i].up;
         vol_down = vv[i].down;
         tick();
         vol_up   = 1'b0;
         vol_down = 1'b0;
         check($sformatf("vol_vec%0d", i), 32'(volume), 32'(vv[i].exp_vol));
      end
      vol_up = 1'b1;
      tick();
      tick();
      vol_up = 1'b0;
      check("vol_back_to_3", 32'(volume), 32'd3);

      // BGM square wave at volume 3: 500 high, 500 low.
      bgm_en  = 1'b1;
      bgm_div = 22'd1000;
      tick();
      check("bgm_latency", 32'(audio_left), 32'h0);
      tick();
      check("bgm_first_high", 32'(audio_left), 32'h0400);
      check("bgm_right_eq_left", 32'(audio_right), 32'(audio_left));
      run_len(16'h0400, 2000, n);
      check("bgm_high_len", 32'(n), 32'd500);
      check("bgm_low_val", 32'(audio_left), 32'hFC00);
      check("bgm_low_right", 32'(audio_right), 32'hFC00);
      run_len(16'hFC00, 2000, n);
      check("bgm_low_len", 32'(n), 32'd500);
      check("bgm_wrap_high", 32'(audio_left), 32'h0400);

      // Mute silences from the next sample and keeps the volume.
      mute = 1'b1;
      tick();
      check("mute_silent", 32'(audio_left), 32'h0);
      check("mute_keeps_vol", 32'(volume), 32'd3);
      run_len(16'h0000, 20, n);
      check("mute_stays_silent", 32'(n), 32'd20);
      mute = 1'b0;

      // SFX0 burst, then gap, then BGM restarts at phase high.
      pulse_req(3'b001);
      t0 = cyc;
      check("sfx0_active", 32'(sfx_active), 32'h1);
      check("sfx0_cur", 32'(cur_sfx), 32'h0);
      tick();
      tick();
      check("sfx0_first_high", 32'(audio_left), 32'h0400);
      run_len(16'h0400, 500, n);
      check("sfx0_high_len", 32'(n), 32'd20);
      run_len(16'hFC00, 500, n);
      check("sfx0_low_len", 32'(n), 32'd20);
      wait_idle(600);
      check("sfx0_burst_len", 32'(cyc - t0), 32'(SFX_CYC));
      check("gap_cur_kept", 32'(cur_sfx), 32'h0);
      tick();
      tick();
      check("gap_silent", 32'(audio_left), 32'h0);
      run_len(16'h0000, 500, n);
      check("gap_len", 32'(n), 32'(GAP_CYC));
      check("bgm_resume_high", 32'(audio_left), 32'h0400);
      run_len(16'h0400, 2000, n);
      check("bgm_resume_high_len", 32'(n), 32'd500);

      // Preempt by SFX2, lower-priority request dropped, timer reloaded.
      pulse_req(3'b001);
      check("pre_cur0", 32'(cur_sfx), 32'h0);
      repeat (50) tick();
      pulse_req(3'b100);
      t0 = cyc;
      check("preempt_cur2", 32'(cur_sfx), 32'h2);
      check("preempt_active", 32'(sfx_active), 32'h1);
      tick();
      tick();
      check("sfx2_first_high", 32'(audio_left), 32'h0400);
      run_len(16'h0400, 500, n);
      check("sfx2_high_len", 32'(n), 32'd10);
      repeat (30) tick();
      pulse_req(3'b010);
      check("low_req_dropped", 32'(cur_sfx), 32'h2);
      wait_idle(600);
      check("preempt_reload_len", 32'(cyc - t0), 32'(SFX_CYC));

      // Request during the gap goes straight to SFX with no BGM samples.
      repeat (30) tick();
      check("in_gap_inactive", 32'(sfx_active), 32'h0);
      pulse_req(3'b001);
      check("gap_req_active", 32'(sfx_active), 32'h1);
      check("gap_req_cur0", 32'(cur_sfx), 32'h0);
      tick();
      check("gap_req_no_bgm", 32'(audio_left), 32'h0);
      tick();
      check("gap_req_sfx_high", 32'(audio_left), 32'h0400);
      run_len(16'h0400, 500, n);
      check("gap_req_sfx0_period", 32'(n), 32'd20);
      repeat (50) tick();
      pulse_req(3'b001);
      t0 = cyc;
      check("retrigger_cur0", 32'(cur_sfx), 32'h0);
      wait_idle(600);
      check("retrigger_len", 32'(cyc - t0), 32'(SFX_CYC));

      // Simultaneous requests in BGM: highest index wins.
      repeat (GAP_CYC + 10) tick();
      pulse_req(3'b011);
      check("dual_req_cur1", 32'(cur_sfx), 32'h1);
      check("dual_req_active", 32'(sfx_active), 32'h1);
      tick();
      tick();
      run_len(16'h0400, 500, n);
      check("sfx1_high_len", 32'(n), 32'd30);
      wait_idle(600);
      repeat (GAP_CYC + 10) tick();

      // BGM disabled, then rest period, then restart at phase high.
      bgm_en = 1'b0;
      tick();
      tick();
      check("bgm_disabled_silent", 32'(audio_left), 32'h0);
      bgm_en  = 1'b1;
      bgm_div = 22'd0;
      tick();
      tick();
      check("bgm_rest_silent", 32'(audio_left), 32'h0);
      run_len(16'h0000, 50, n);
      check("bgm_rest_stays", 32'(n), 32'd50);
      bgm_div = 22'd1000;
      tick();
      check("bgm_note_latency", 32'(audio_left), 32'h0);
      tick();
      check("bgm_note_restart_high", 32'(audio_left), 32'h0400);
      run_len(16'h0400, 2000, n);
      check("bgm_note_high_len", 32'(n), 32'd500);

      // Asynchronous reset in the middle of a burst at volume 5.
      vol_up = 1'b1;
      tick();
      tick();
      vol_up = 1'b0;
      check("vol_5", 32'(volume), 32'd5);
      pulse_req(3'b100);
      repeat (10) tick();
      check("pre_rst_active", 32'(sfx_active), 32'h1);
      check("vol5_amp", 32'(audio_left), 32'h1000);
      #2;
      rst     = 1'b1;
      sfx_req = 3'b001;
      #1;
      check("async_rst_audio_l", 32'(audio_left), 32'h0);
      check("async_rst_audio_r", 32'(audio_right), 32'h0);
      check("async_rst_volume", 32'(volume), 32'(VOL_INIT));
      check("async_rst_active", 32'(sfx_active), 32'h0);
      check("async_rst_cur", 32'(cur_sfx), 32'h0);
      tick();
      sfx_req = 3'b000;
      #2;
      rst = 1'b0;
      repeat (3) tick();
      check("post_rst_no_pending", 32'(sfx_active), 32'h0);
      check("post_rst_cur", 32'(cur_sfx), 32'h0);
      check("post_rst_volume", 32'(volume), 32'(VOL_INIT));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
